// File: rtl/alu_cmd_driver.sv
// Command FIFO + sequencer driving one combinational ALU. Captures Z/flags after a
// fixed settle time and keeps an accumulator so commands can chain on prior results.
module alu_cmd_driver #(
  parameter int W          = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic [2:0]   alu_c,
  input  logic [W-1:0] alu_z,
  input  logic         alu_cout,
  input  logic         alu_ov,
  input  logic         alu_zf,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_z,
  output logic [3:0]   rsp_flags,
  output logic [W-1:0] acc,
  output logic         busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_acc;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          cur;
  state_t        state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [CW-1:0] cnt;
  logic          push, pop;

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state == IDLE) && (count != '0) && !rsp_valid;
  assign busy = (state != IDLE) || (count != '0);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (pop && !push) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
  end

  // cmd_ready is registered so it stays low through reset and rises one cycle after
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      cmd_ready <= (count_nxt != FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_c     <= '0;
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_flags <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          cur   <= mem[rd_ptr];
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= CW'(SETTLE);
          // remainder by zero never reaches the ALU; its inputs keep their old values
          if (cur.op == 3'b010 && cur.b == '0) begin
            rsp_z     <= '0;
            rsp_flags <= 4'b1000;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            alu_x <= cur.use_acc ? acc : cur.a;
            alu_y <= cur.b;
            alu_c <= cur.op;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            rsp_z     <= alu_z;
            rsp_flags <= {1'b0, alu_zf, alu_ov, alu_cout};
            acc       <= alu_z;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: behavioural ALU, response scoreboard, latency,
// backpressure and mid-operation reset.
module tb_alu_cmd_driver;
  localparam int W = 8, DEPTH = 4, SETTLE = 3;

  typedef struct packed { logic [W-1:0] z; logic [3:0] f; } rsp_t;

  logic         clk = 1'b0, reset;
  logic         cmd_valid, cmd_ready, cmd_use_acc;
  logic [2:0]   cmd_op, alu_c;
  logic [W-1:0] cmd_a, cmd_b, alu_x, alu_y, alu_z, rsp_z, acc;
  logic         alu_cout, alu_ov, alu_zf, rsp_valid, rsp_ready, busy;
  logic [3:0]   rsp_flags;

  int           checks = 0, errors = 0, cyc = 0, npop = 0, acc_cyc = 0;
  rsp_t         sb[$];
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] last_z = '0;
  logic [3:0]   last_f = '0;

  alu_cmd_driver #(.W(W), .FIFO_DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z),
    .alu_cout(alu_cout), .alu_ov(alu_ov), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
    .rsp_flags(rsp_flags), .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // behavioural 8-bit ALU: returns {ZeroFlag, OV, Cout, Z}
  function automatic logic [W+2:0] alu_f(input logic [W-1:0] x, y, input logic [2:0] c);
    logic [W:0]   s;
    logic [W-1:0] z;
    logic         co, ov;
    z = '0; co = 1'b0; ov = 1'b0;
    case (c)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; z = s[W-1:0]; co = s[W];
                  ov = (x[W-1] == y[W-1]) && (z[W-1] != x[W-1]); end
      3'd1: begin s = {1'b0, x} - {1'b0, y}; z = s[W-1:0]; co = s[W];
                  ov = (x[W-1] != y[W-1]) && (z[W-1] != x[W-1]); end
      3'd2: z = (y == '0) ? '0 : x % y;
      3'd3: z = x & y;
      3'd4: z = x | y;
      3'd5: z = {x[W/2-1:0], y[W/2-1:0]};
      3'd6: z = {{(W-1){1'b0}}, x == y};
      default: z = {{(W-1){1'b0}}, x < y};
    endcase
    return {z == '0, ov, co, z};
  endfunction

  assign {alu_zf, alu_ov, alu_cout, alu_z} = alu_f(alu_x, alu_y, alu_c);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer: a response is taken on the edge following this sample
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_rsp: observed z=%0h flags=%0h expected no response", rsp_z, rsp_flags);
        end
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_z", 32'(rsp_z), 32'(e.z));
        chk("rsp_flags", 32'(rsp_flags), 32'(e.f));
        last_z = rsp_z;
        last_f = rsp_flags;
        npop++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, b, input logic ua);
    logic [W+2:0] r;
    logic [W-1:0] x;
    bit ok;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1; ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    chk("cmd_accept", 32'(ok), 32'(1));
    if (ok) begin
      x = ua ? m_acc : a;
      if (op == 3'b010 && b == '0) sb.push_back('{z: '0, f: 4'b1000});
      else begin
        r = alu_f(x, b, op);
        sb.push_back('{z: r[W-1:0], f: {1'b0, r[W+2:W]}});
        m_acc = r[W-1:0];
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !rsp_valid) done = 1;
    end
    chk(tag, 32'(done), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat, p0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_acc", 32'(acc), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(negedge clk); reset = 1'b0; #1;
    chk("ready_before_edge", 32'(cmd_ready), 32'(0));
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(cmd_ready), 32'(1));

    // add with signed overflow
    send(3'b000, 8'h7F, 8'h01, 1'b0);
    drain("drain_add");
    chk("add_z", 32'(last_z), 32'h80);
    chk("add_flags", 32'(last_f), 32'b0010);
    chk("add_acc", 32'(acc), 32'h80);

    // latency from acceptance edge to first rsp_valid
    send(3'b011, 8'hF0, 8'h3C, 1'b0);
    lat = -1;
    for (int i = 0; i < 30 && lat < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) lat = cyc - acc_cyc;
    end
    chk("latency", 32'(lat), 32'(SETTLE + 2));
    drain("drain_lat");

    // sub to zero, then chain on the accumulator
    send(3'b001, 8'h05, 8'h05, 1'b0);
    send(3'b000, 8'hAA, 8'h03, 1'b1);
    drain("drain_chain");
    chk("chain_z", 32'(last_z), 32'h03);
    chk("chain_acc", 32'(acc), 32'h03);

    // remainder by zero: error flag, acc and ALU inputs untouched
    send(3'b010, 8'h09, 8'h00, 1'b0);
    drain("drain_rem0");
    chk("rem0_z", 32'(last_z), 32'h00);
    chk("rem0_flags", 32'(last_f), 32'b1000);
    chk("rem0_acc", 32'(acc), 32'h03);
    chk("rem0_alu_c", 32'(alu_c), 32'b000);
    chk("rem0_alu_y", 32'(alu_y), 32'h03);

    // remaining opcodes back to back
    send(3'b010, 8'h17, 8'h05, 1'b0);
    send(3'b100, 8'h50, 8'h0A, 1'b1);
    send(3'b101, 8'h12, 8'h34, 1'b0);
    send(3'b110, 8'h42, 8'h42, 1'b1);
    send(3'b111, 8'h03, 8'h80, 1'b0);
    send(3'b001, 8'h00, 8'h01, 1'b1);
    drain("drain_ops");

    // backpressure: one in flight plus a full FIFO
    rsp_ready = 1'b0;
    p0 = npop;
    send(3'b000, 8'h10, 8'h01, 1'b0);
    send(3'b000, 8'h20, 8'h02, 1'b0);
    send(3'b000, 8'h30, 8'h03, 1'b1);
    send(3'b011, 8'h40, 8'hFF, 1'b0);
    send(3'b000, 8'h50, 8'h05, 1'b1);
    @(negedge clk);
    chk("bp_full", 32'(cmd_ready), 32'(0));
    chk("bp_busy", 32'(busy), 32'(1));
    repeat (8) @(negedge clk);
    chk("bp_rsp_held", 32'(rsp_valid), 32'(1));
    chk("bp_rsp_z", 32'(rsp_z), 32'(sb[0].z));
    chk("bp_still_full", 32'(cmd_ready), 32'(0));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("drain_bp");
    chk("bp_count", 32'(npop - p0), 32'(5));

    // reset while WAIT with two commands queued
    send(3'b000, 8'h11, 8'h22, 1'b0);
    send(3'b000, 8'h01, 8'h01, 1'b0);
    send(3'b000, 8'h02, 8'h02, 1'b0);
    reset = 1'b1; #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_acc", 32'(acc), 32'(0));
    chk("mid_rst_alu", 32'({alu_x, alu_y, alu_c}), 32'(0));
    chk("mid_rst_rsp", 32'({rsp_z, rsp_flags}), 32'(0));
    sb.delete();
    m_acc = '0;
    p0 = npop;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'(0));
    chk("post_rst_no_rsp", 32'(npop - p0), 32'(0));

    // recovers cleanly after the reset
    @(posedge clk); #1;
    send(3'b001, 8'h10, 8'h01, 1'b1);
    drain("drain_recover");
    chk("recover_z", 32'(last_z), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
